vram_write_arbiter: RTL and testbench
=====================================

# vram_write_arbiter

Owns the single port of the vector RAM BRAM and shares it between the CPU-side store queue (drain end of `memStoreQueue`) and the vector generator's read requests. Each cycle it grants the port to exactly one requester. It drives the queue's `canWrite` pop strobe and commits the popped byte to BRAM. It returns vector-generator read data with fixed 1-cycle latency. A starvation counter guarantees the store queue drains even while the vector generator streams continuously.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: maximum consecutive vector-generator grants while the queue is pending; range 1..15.
- `VRAM_BASE`, 16'h2000: first CPU address of the vector RAM window.
- `VRAM_AW`, 13: BRAM address width; window size is 2^VRAM_AW bytes.

Ports:
- `clk` in 1: single system clock; all logic on posedge.
- `rst` in 1: reset, synchronous, active-low. `rst==0` at a posedge resets all state.
- `sq_pending` in 1: store queue non-empty (queue `!empty`).
- `sq_can_write` out 1: pop grant to queue (`canWrite`).
- `sq_write` in 1: queue `writeOut`; high means `sq_data`/`sq_addr` are valid this cycle and the entry pops at this edge.
- `sq_data` in 8: queue `Q`.
- `sq_addr` in 16: queue `writeAddr`, CPU address.
- `vg_req` in 1: vector generator read request; held until acked.
- `vg_addr` in VRAM_AW: BRAM-local read address.
- `vg_ack` out 1: request accepted this cycle.
- `vg_rvalid` out 1: `vg_rdata` valid.
- `vg_rdata` out 8: read data.
- `bram_addr` out VRAM_AW: BRAM port address.
- `bram_din` out 8: BRAM write data.
- `bram_we` out 1: BRAM write enable.
- `bram_dout` in 8: BRAM read data, registered 1 cycle after address.
- `drop_err` out 1: sticky flag; an out-of-window store was discarded.

## Operation
- Grant is computed combinationally each cycle from `sq_pending`, `vg_req` and `starve_cnt`:
  - If `vg_req && !(sq_pending && starve_cnt==STARVE_LIMIT)`: grant VG.
  - Else if `sq_pending`: grant SQ.
  - Else: idle.
- VG grant:
  - `vg_ack=1`, `bram_addr=vg_addr`, `bram_we=0`, `sq_can_write=0`.
  - Registered `rd_pend` is set.
- SQ grant:
  - `sq_can_write=1`, `vg_ack=0`.
  - If `sq_write`, and `sq_addr` is in [VRAM_BASE, VRAM_BASE+2^VRAM_AW): `bram_we=1`, `bram_addr=sq_addr-VRAM_BASE` (low VRAM_AW bits), `bram_din=sq_data`.
  - If `sq_write` and the address is out of window: `bram_we=0`, the entry still pops, and `drop_err` sets and stays set until reset.
  - If `sq_write==0` despite the grant (queue drained): no write, no error.
- Idle: all strobes 0, `bram_addr=0`.
- `starve_cnt` (4 bits), updated per cycle:
  - `+1` when VG is granted while `sq_pending`.
  - Cleared on any SQ grant or when `!sq_pending`.
  - Saturates at STARVE_LIMIT.
- Read return: `vg_rvalid <= rd_pend`; `vg_rdata = bram_dout` whenever `vg_rvalid`, otherwise 0.
- Ordering: at most one BRAM op per cycle. A write committed at edge N is visible to a read issued at cycle N+1 or later.

## Timing
- Reset values: `sq_can_write=0`, `vg_ack=0`, `vg_rvalid=0`, `vg_rdata=0`, `bram_we=0`, `bram_addr=0`, `bram_din=0`, `drop_err=0`, `starve_cnt=0`, `rd_pend=0`.
- While `rst==0`, all combinational grants are forced to 0.
- Read latency: `vg_ack` in cycle N gives `vg_rvalid` in cycle N+1, carrying BRAM contents at `vg_addr` after any write committed at edge N-1 or earlier.
- Back-to-back reads: one per cycle with `vg_req` held high; throughput 1 byte/cycle except starvation slots.
- Store drain: 1 entry/cycle while SQ is granted; pop and BRAM write share the same edge.
- Simultaneous `vg_req` and `sq_pending`: VG wins for STARVE_LIMIT cycles, then SQ gets exactly one cycle, then the counter restarts.
- Reset mid-read: an ack in cycle N with `rst==0` at edge N means no `vg_rvalid` in N+1; the requester reissues.
- Window edges:
  - `sq_addr = VRAM_BASE + 2^VRAM_AW - 1` is accepted.
  - `VRAM_BASE + 2^VRAM_AW` and `VRAM_BASE - 1` are dropped with `drop_err`.

## Test plan
- Reset: hold `rst=0` 3 cycles while driving `vg_req=1`, `sq_pending=1` -> every output 0; first cycle after release grants VG (`starve_cnt=0`).
- Drain only: queue holds stores 0x2000←0xA5, 0x2001←0x5A, `vg_req=0` -> `sq_can_write` high 2 cycles, BRAM writes at local 0x0000/0x0001; read back 0x0000 gives `vg_rvalid` one cycle after ack with 0xA5.
- Starvation, STARVE_LIMIT=4: `vg_req` held high, `sq_pending=1` -> pattern VG,VG,VG,VG,SQ,VG… ; `vg_ack` low only in the SQ slot; `vg_rvalid` gap exactly one cycle.
- Out-of-window: store to 0x4000 data 0x77 -> entry pops, `bram_we=0`, `drop_err=1` next cycle and sticky; store to 0x3FFF is written, no new error.
- Write-then-read hazard: store 0x2010←0x3C granted cycle N, VG read 0x0010 acked N+1 -> `vg_rdata=0x3C` at N+2.
- Reset mid-read: ack at N, `rst=0` at edge N -> `vg_rvalid=0` at N+1; `drop_err` cleared.

Source files
------------

// File: rtl/vram_write_arbiter.sv
// Single-port vector RAM arbiter: shares the BRAM port between store-queue drains and
// vector-generator reads, with a starvation bound that guarantees the store queue makes progress.
module vram_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [15:0] VRAM_BASE    = 16'h2000,
  parameter int unsigned VRAM_AW      = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sq_pending,
  output logic               sq_can_write,
  input  logic               sq_write,
  input  logic [7:0]         sq_data,
  input  logic [15:0]        sq_addr,
  input  logic               vg_req,
  input  logic [VRAM_AW-1:0] vg_addr,
  output logic               vg_ack,
  output logic               vg_rvalid,
  output logic [7:0]         vg_rdata,
  output logic [VRAM_AW-1:0] bram_addr,
  output logic [7:0]         bram_din,
  output logic               bram_we,
  input  logic [7:0]         bram_dout,
  output logic               drop_err
);

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_VG,
    GNT_SQ
  } grant_t;

  localparam logic [3:0]  LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [16:0] WIN_SIZE = 17'(1) << VRAM_AW;

  logic [3:0]  r_starve_cnt;
  logic        r_rd_pend;
  logic        r_drop_err;

  grant_t      w_grant;
  logic [16:0] w_off;
  logic        w_in_win;
  logic        w_sq_drop;

  // 17-bit subtraction: addresses below the base wrap to large values and fail the bound check.
  assign w_off    = {1'b0, sq_addr} - {1'b0, VRAM_BASE};
  assign w_in_win = (w_off < WIN_SIZE);

  always_comb begin
    w_grant = GNT_IDLE;
    if (rst) begin
      if (vg_req && !(sq_pending && (r_starve_cnt == LIMIT))) begin
        w_grant = GNT_VG;
      end else if (sq_pending) begin
        w_grant = GNT_SQ;
      end
    end
  end

  always_comb begin
    vg_ack       = 1'b0;
    sq_can_write = 1'b0;
    bram_we      = 1'b0;
    bram_addr    = '0;
    bram_din     = '0;
    w_sq_drop    = 1'b0;
    unique case (w_grant)
      GNT_VG: begin
        vg_ack    = 1'b1;
        bram_addr = vg_addr;
      end
      GNT_SQ: begin
        sq_can_write = 1'b1;
        if (sq_write) begin
          if (w_in_win) begin
            bram_we   = 1'b1;
            bram_addr = w_off[VRAM_AW-1:0];
            bram_din  = sq_data;
          end else begin
            w_sq_drop = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_starve_cnt <= '0;
      r_rd_pend    <= 1'b0;
      r_drop_err   <= 1'b0;
    end else begin
      r_rd_pend <= (w_grant == GNT_VG);
      if (w_sq_drop) begin
        r_drop_err <= 1'b1;
      end
      if ((w_grant == GNT_SQ) || !sq_pending) begin
        r_starve_cnt <= '0;
      end else if ((w_grant == GNT_VG) && (r_starve_cnt < LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

  // BRAM output is registered, so the data lines up with the cycle after the ack.
  assign vg_rvalid = r_rd_pend;
  assign vg_rdata  = r_rd_pend ? bram_dout : '0;
  assign drop_err  = r_drop_err;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (store FIFO, byte memory, starvation run length).
module tb_vram_write_arbiter;

  localparam int LIMIT = 4;
  localparam int BASE  = 'h2000;
  localparam int WIN   = 8192;

  logic        clk;
  logic        rst;
  logic        sq_pending;
  logic        sq_can_write;
  logic        sq_write;
  logic [7:0]  sq_data;
  logic [15:0] sq_addr;
  logic        vg_req;
  logic [12:0] vg_addr;
  logic        vg_ack;
  logic        vg_rvalid;
  logic [7:0]  vg_rdata;
  logic [12:0] bram_addr;
  logic [7:0]  bram_din;
  logic        bram_we;
  logic [7:0]  bram_dout;
  logic        drop_err;

  int checks = 0;
  int failures = 0;

  vram_write_arbiter #(.STARVE_LIMIT(4), .VRAM_BASE(16'h2000), .VRAM_AW(13)) dut (
    .clk(clk), .rst(rst),
    .sq_pending(sq_pending), .sq_can_write(sq_can_write), .sq_write(sq_write),
    .sq_data(sq_data), .sq_addr(sq_addr),
    .vg_req(vg_req), .vg_addr(vg_addr), .vg_ack(vg_ack),
    .vg_rvalid(vg_rvalid), .vg_rdata(vg_rdata),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
    .bram_dout(bram_dout), .drop_err(drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM environment: one registered port
  bit [7:0] mem [0:8191];
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_din;
    bram_dout <= mem[bram_addr];
  end

  // Reference model state
  typedef struct { logic [15:0] addr; logic [7:0] data; } st_t;
  st_t      sq_q[$];
  bit [7:0] ref_mem [0:8191];
  int       m_run = 0;
  bit       m_drop = 0;
  bit       m_rv = 0;
  bit [7:0] m_rd = 0;
  bit       e_vg, e_sq, e_we;
  bit [12:0] e_addr;
  bit [7:0]  e_din;

  function automatic bit in_win(input logic [15:0] a);
    return (int'(a) >= BASE) && (int'(a) < BASE + WIN);
  endfunction

  task automatic drive_sq();
    sq_pending = (sq_q.size() != 0);
    sq_write   = sq_pending;
    sq_addr    = sq_pending ? sq_q[0].addr : 16'h0;
    sq_data    = sq_pending ? sq_q[0].data : 8'h0;
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d);
    st_t s;
    s.addr = a;
    s.data = d;
    sq_q.push_back(s);
    drive_sq();
  endtask

  task automatic predict();
    bit pend;
    pend   = (sq_q.size() != 0);
    e_vg   = 0; e_sq = 0; e_we = 0; e_addr = '0; e_din = '0;
    if (rst) begin
      e_vg = vg_req && !(pend && m_run == LIMIT);
      e_sq = !e_vg && pend;
    end
    if (e_vg) e_addr = vg_addr;
    if (e_sq && in_win(sq_q[0].addr)) begin
      e_we   = 1;
      e_addr = 13'(sq_q[0].addr - 16'(BASE));
      e_din  = sq_q[0].data;
    end
  endtask

  task automatic advance();
    bit pend;
    pend = (sq_q.size() != 0);
    if (!rst) begin
      m_run = 0; m_drop = 0; m_rv = 0; m_rd = 0;
    end else begin
      m_rv = e_vg;
      if (e_vg) m_rd = ref_mem[vg_addr];
      if (e_sq) begin
        st_t h;
        h = sq_q.pop_front();
        if (in_win(h.addr)) ref_mem[13'(h.addr - 16'(BASE))] = h.data;
        else m_drop = 1;
      end
      if (e_sq || !pend) m_run = 0;
      else if (e_vg && m_run < LIMIT) m_run++;
    end
  endtask

  task automatic settle();
    #1;
    predict();
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    #1;
    advance();
    drive_sq();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 0; vg_req = 1; vg_addr = 13'h5;
    push(16'h2100, 8'h42);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (vg_ack !== 1'b0) begin failures++; $display("FAIL rst_vg_ack got=%0b exp=0", vg_ack); end
      checks++; if (sq_can_write !== 1'b0) begin failures++; $display("FAIL rst_sq_can_write got=%0b exp=0", sq_can_write); end
      checks++; if (bram_we !== 1'b0 || bram_addr !== 13'h0 || bram_din !== 8'h0) begin failures++; $display("FAIL rst_bram got we=%0b addr=%h din=%h exp 0", bram_we, bram_addr, bram_din); end
      checks++; if (vg_rvalid !== 1'b0 || vg_rdata !== 8'h0) begin failures++; $display("FAIL rst_read got rv=%0b rd=%h exp 0", vg_rvalid, vg_rdata); end
      checks++; if (drop_err !== 1'b0) begin failures++; $display("FAIL rst_drop_err got=%0b exp=0", drop_err); end
      tick();
    end
    rst = 1;
    settle();
    checks++; if (vg_ack !== 1'b1 || sq_can_write !== 1'b0) begin failures++; $display("FAIL rst_release_grant got ack=%0b cw=%0b exp ack=1 cw=0", vg_ack, sq_can_write); end
    checks++; if (bram_addr !== 13'h5) begin failures++; $display("FAIL rst_release_addr got=%h exp=0005", bram_addr); end
    tick();
    vg_req = 0;
    for (int i = 0; i < 4 && sq_q.size() != 0; i++) tick();
    tick();
  endtask

  task automatic test_drain();
    vg_req = 0;
    push(16'h2000, 8'hA5);
    push(16'h2001, 8'h5A);
    settle();
    checks++; if (sq_can_write !== 1'b1 || bram_we !== 1'b1 || bram_addr !== 13'h0 || bram_din !== 8'hA5) begin failures++; $display("FAIL drain_first got cw=%0b we=%0b addr=%h din=%h exp 1 1 0000 a5", sq_can_write, bram_we, bram_addr, bram_din); end
    tick(); settle();
    checks++; if (sq_can_write !== 1'b1 || bram_we !== 1'b1 || bram_addr !== 13'h1 || bram_din !== 8'h5A) begin failures++; $display("FAIL drain_second got cw=%0b we=%0b addr=%h din=%h exp 1 1 0001 5a", sq_can_write, bram_we, bram_addr, bram_din); end
    tick(); settle();
    checks++; if (sq_can_write !== 1'b0 || bram_we !== 1'b0) begin failures++; $display("FAIL drain_done got cw=%0b we=%0b exp 0 0", sq_can_write, bram_we); end
    vg_req = 1; vg_addr = 13'h0;
    settle();
    checks++; if (vg_ack !== 1'b1) begin failures++; $display("FAIL drain_read_ack got=%0b exp=1", vg_ack); end
    tick();
    vg_req = 0;
    settle();
    checks++; if (vg_rvalid !== 1'b1 || vg_rdata !== 8'hA5) begin failures++; $display("FAIL drain_readback got rv=%0b rd=%h exp 1 a5", vg_rvalid, vg_rdata); end
    tick();
  endtask

  task automatic test_starvation();
    bit prev_ack;
    bit exp_sq;
    vg_req = 1;
    for (int i = 0; i < 3; i++) push(16'(BASE + 'h40 + i), 8'($urandom_range(0, 255)));
    prev_ack = 0;
    for (int i = 0; i < 15; i++) begin
      vg_addr = 13'($urandom_range(0, 'h47));
      settle();
      exp_sq = ((i % (LIMIT + 1)) == LIMIT);
      checks++; if (vg_ack !== !exp_sq || sq_can_write !== exp_sq) begin failures++; $display("FAIL starve_slot%0d got ack=%0b cw=%0b exp ack=%0b cw=%0b", i, vg_ack, sq_can_write, !exp_sq, exp_sq); end
      if (i > 0) begin
        checks++; if (vg_rvalid !== prev_ack) begin failures++; $display("FAIL starve_rvalid%0d got=%0b exp=%0b", i, vg_rvalid, prev_ack); end
        checks++; if (vg_rdata !== (m_rv ? m_rd : 8'h0)) begin failures++; $display("FAIL starve_rdata%0d got=%h exp=%h", i, vg_rdata, (m_rv ? m_rd : 8'h0)); end
      end
      prev_ack = !exp_sq;
      tick();
    end
    vg_req = 0;
    tick();
  endtask

  task automatic test_out_of_window();
    vg_req = 0;
    push(16'h4000, 8'h77);
    settle();
    checks++; if (sq_can_write !== 1'b1 || bram_we !== 1'b0 || drop_err !== 1'b0) begin failures++; $display("FAIL oow_high got cw=%0b we=%0b err=%0b exp 1 0 0", sq_can_write, bram_we, drop_err); end
    tick(); settle();
    checks++; if (drop_err !== 1'b1 || sq_can_write !== 1'b0) begin failures++; $display("FAIL oow_err_set got err=%0b cw=%0b exp 1 0", drop_err, sq_can_write); end
    push(16'h3FFF, 8'h11);
    settle();
    checks++; if (bram_we !== 1'b1 || bram_addr !== 13'h1FFF || bram_din !== 8'h11) begin failures++; $display("FAIL oow_top_edge got we=%0b addr=%h din=%h exp 1 1fff 11", bram_we, bram_addr, bram_din); end
    tick();
    push(16'h1FFF, 8'h99);
    settle();
    checks++; if (bram_we !== 1'b0 || sq_can_write !== 1'b1) begin failures++; $display("FAIL oow_low got we=%0b cw=%0b exp 0 1", bram_we, sq_can_write); end
    tick(); settle();
    checks++; if (drop_err !== 1'b1) begin failures++; $display("FAIL oow_sticky got=%0b exp=1", drop_err); end
    vg_req = 1; vg_addr = 13'h1FFF;
    tick();
    vg_req = 0;
    settle();
    checks++; if (vg_rvalid !== 1'b1 || vg_rdata !== 8'h11) begin failures++; $display("FAIL oow_readback got rv=%0b rd=%h exp 1 11", vg_rvalid, vg_rdata); end
    tick();
  endtask

  task automatic test_hazard();
    vg_req = 0;
    push(16'h2010, 8'h3C);
    settle();
    checks++; if (sq_can_write !== 1'b1 || bram_we !== 1'b1) begin failures++; $display("FAIL hazard_write got cw=%0b we=%0b exp 1 1", sq_can_write, bram_we); end
    tick();
    vg_req = 1; vg_addr = 13'h10;
    settle();
    checks++; if (vg_ack !== 1'b1) begin failures++; $display("FAIL hazard_ack got=%0b exp=1", vg_ack); end
    tick();
    vg_req = 0;
    settle();
    checks++; if (vg_rvalid !== 1'b1 || vg_rdata !== 8'h3C) begin failures++; $display("FAIL hazard_read got rv=%0b rd=%h exp 1 3c", vg_rvalid, vg_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    vg_req = 1; vg_addr = 13'h10; rst = 0;
    settle();
    checks++; if (vg_ack !== 1'b0) begin failures++; $display("FAIL midrst_ack got=%0b exp=0", vg_ack); end
    tick();
    rst = 1; vg_req = 0;
    settle();
    checks++; if (vg_rvalid !== 1'b0 || drop_err !== 1'b0) begin failures++; $display("FAIL midrst_state got rv=%0b err=%0b exp 0 0", vg_rvalid, drop_err); end
    tick();
  endtask

  task automatic test_random();
    int k;
    logic [15:0] a;
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(0, 63) != 0);
      vg_req  = ($urandom_range(0, 99) < 65);
      vg_addr = 13'($urandom_range(0, 31));
      if (sq_q.size() < 6 && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 9);
        case (k)
          0: a = 16'h1FFF;
          1: a = 16'h4000;
          2: a = 16'h3FFF;
          3: a = 16'($urandom_range(0, 65535));
          default: a = 16'(BASE + $urandom_range(0, 31));
        endcase
        push(a, 8'($urandom_range(0, 255)));
      end
      settle();
      checks++; if (vg_ack !== e_vg) begin failures++; $display("FAIL rnd_ack c=%0d got=%0b exp=%0b", c, vg_ack, e_vg); end
      checks++; if (sq_can_write !== e_sq) begin failures++; $display("FAIL rnd_can_write c=%0d got=%0b exp=%0b", c, sq_can_write, e_sq); end
      checks++; if (bram_we !== e_we) begin failures++; $display("FAIL rnd_we c=%0d got=%0b exp=%0b", c, bram_we, e_we); end
      checks++; if (bram_addr !== e_addr) begin failures++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, bram_addr, e_addr); end
      checks++; if (bram_din !== e_din) begin failures++; $display("FAIL rnd_din c=%0d got=%h exp=%h", c, bram_din, e_din); end
      checks++; if (vg_rvalid !== m_rv) begin failures++; $display("FAIL rnd_rvalid c=%0d got=%0b exp=%0b", c, vg_rvalid, m_rv); end
      checks++; if (vg_rdata !== (m_rv ? m_rd : 8'h0)) begin failures++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, vg_rdata, (m_rv ? m_rd : 8'h0)); end
      checks++; if (drop_err !== m_drop) begin failures++; $display("FAIL rnd_drop_err c=%0d got=%0b exp=%0b", c, drop_err, m_drop); end
      tick();
    end
  endtask

  initial begin
    rst = 0; vg_req = 0; vg_addr = '0;
    drive_sq();
    @(negedge clk);
    test_reset();
    test_drain();
    test_starvation();
    test_out_of_window();
    test_hazard();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
